// File: rtl/sched_pkg.sv
// Shared types and elaboration-time helpers for the tile scheduler.
// No logic; constants only.
// No flow control.
package sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    // Length of the compute window: the wavefront crosses ROWS+COLS-1 PEs.
    function automatic int compute_cycles(input int rows, input int cols, input int pe_latency);
        return (rows + cols - 1) * pe_latency;
    endfunction

    // Width that holds the longest phase length without wrapping.
    function automatic int phase_cnt_width(input int rows, input int compute, input int drain);
        int m;
        m = rows;
        if (compute > m) m = compute;
        if (drain > m)   m = drain;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable phase down-counter with last-cycle flag and zero-based up-count.
// Load takes effect at the next edge; last is combinational from the count.
// en low holds both counts; the caller only loads while enabled.
module phase_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         last,
    output logic [W-1:0] up_cnt
);

    logic [W-1:0] remain;

    // Reload on phase entry, otherwise count down and stop at zero (never wraps).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remain <= '0;
            up_cnt <= '0;
        end else if (load) begin
            remain <= len - W'(1);
            up_cnt <= '0;
        end else if (en && (remain != '0)) begin
            remain <= remain - W'(1);
            up_cnt <= up_cnt + W'(1);
        end
    end

    assign last = (remain == '0);

endmodule

// File: rtl/tile_scheduler.sv
// Systolic-array sequencer: per tile LOAD (one-hot rows), COMPUTE, DRAIN; start/busy/done handshake.
// First load_weight strobe one cycle after an accepted start; tile period ROWS+C+DRAIN_CYCLES.
// general_enable low freezes everything and blanks the strobes; start is ignored while busy.
module tile_scheduler
    import sched_pkg::*;
#(
    parameter int ROWS         = 2,
    parameter int COLS         = 2,
    parameter int PE_LATENCY   = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int TILE_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              general_enable,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    output logic [ROWS-1:0]   load_weight,
    output logic [ROWS-1:0]   enable_mult,
    output logic              busy,
    output logic              tile_done,
    output logic [TILE_W-1:0] tile_idx,
    output logic              done
);

    localparam int C  = compute_cycles(ROWS, COLS, PE_LATENCY);
    localparam int CW = phase_cnt_width(ROWS, C, DRAIN_CYCLES);

    localparam logic [CW-1:0] LEN_LOAD  = CW'(ROWS);
    localparam logic [CW-1:0] LEN_COMP  = CW'(C);
    localparam logic [CW-1:0] LEN_DRAIN = CW'(DRAIN_CYCLES);

    state_t            state, next_state;
    logic [TILE_W-1:0] tile_cnt;
    logic              accept;
    logic              more_tiles;
    logic              advance_tile;
    logic              ph_load;
    logic [CW-1:0]     ph_len;
    logic              ph_last;
    logic [CW-1:0]     ph_up;

    assign accept     = general_enable && start && ((state == IDLE) || (state == DONE));
    assign more_tiles = ({1'b0, tile_idx} + (TILE_W+1)'(1)) < {1'b0, tile_cnt};

    phase_counter #(.W(CW)) u_phase (
        .clk    (clk),
        .reset  (reset),
        .en     (general_enable),
        .load   (ph_load),
        .len    (ph_len),
        .last   (ph_last),
        .up_cnt (ph_up)
    );

    // Next-state decode; every phase entry reloads the phase counter.
    always_comb begin
        next_state   = state;
        ph_load      = 1'b0;
        ph_len       = LEN_LOAD;
        advance_tile = 1'b0;
        if (general_enable) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (num_tiles == '0) begin
                            next_state = DONE;
                        end else begin
                            next_state = LOAD;
                            ph_load    = 1'b1;
                            ph_len     = LEN_LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (ph_last) begin
                        next_state = COMPUTE;
                        ph_load    = 1'b1;
                        ph_len     = LEN_COMP;
                    end
                end
                COMPUTE: begin
                    if (ph_last) begin
                        next_state = DRAIN;
                        ph_load    = 1'b1;
                        ph_len     = LEN_DRAIN;
                    end
                end
                DRAIN: begin
                    if (ph_last) begin
                        if (more_tiles) begin
                            next_state   = LOAD;
                            ph_load      = 1'b1;
                            ph_len       = LEN_LOAD;
                            advance_tile = 1'b1;
                        end else begin
                            next_state = DONE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Tile count captured on an accepted start; index advances between tiles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_cnt <= '0;
            tile_idx <= '0;
        end else if (accept) begin
            tile_cnt <= num_tiles;
            tile_idx <= '0;
        end else if (advance_tile) begin
            tile_idx <= tile_idx + TILE_W'(1);
        end
    end

    // Moore strobe decode, blanked while paused.
    always_comb begin
        load_weight = '0;
        enable_mult = '0;
        tile_done   = 1'b0;
        if (general_enable) begin
            case (state)
                LOAD:    load_weight = ROWS'(1) << ph_up;
                COMPUTE: enable_mult = '1;
                DRAIN:   tile_done   = ph_last;
                default: ;
            endcase
        end
    end

    assign busy = (state == LOAD) || (state == COMPUTE) || (state == DRAIN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: two configurations share one stimulus stream.
// Outputs are checked each cycle against a position-in-run model, plus literal timing pins.
// Random phase mixes pauses, starts while busy and occasional resets.
module tb_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       ge;
    logic       start;
    logic [7:0] num_tiles;

    logic [1:0] lw0, em0;
    logic       busy0, td0, dn0;
    logic [7:0] idx0;
    logic [3:0] lw1, em1;
    logic       busy1, td1, dn1;
    logic [7:0] idx1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tile_scheduler #(.ROWS(2), .COLS(2), .PE_LATENCY(4), .DRAIN_CYCLES(4), .TILE_W(8)) dut0 (
        .clk(clk), .reset(rst), .general_enable(ge), .start(start), .num_tiles(num_tiles),
        .load_weight(lw0), .enable_mult(em0), .busy(busy0), .tile_done(td0),
        .tile_idx(idx0), .done(dn0)
    );

    tile_scheduler #(.ROWS(4), .COLS(3), .PE_LATENCY(2), .DRAIN_CYCLES(4), .TILE_W(8)) dut1 (
        .clk(clk), .reset(rst), .general_enable(ge), .start(start), .num_tiles(num_tiles),
        .load_weight(lw1), .enable_mult(em1), .busy(busy1), .tile_done(td1),
        .tile_idx(idx1), .done(dn1)
    );

    // Model: mode 0 idle, 1 running, 2 done; pos counts enabled cycles since the run began.
    int rows_a [2] = '{2, 4};
    int comp_a [2] = '{(2 + 2 - 1) * 4, (4 + 3 - 1) * 2};
    int drain_a[2] = '{4, 4};
    int m_mode [2];
    int m_pos  [2];
    int m_n    [2];
    int m_hold [2];

    function automatic int period(input int k);
        return rows_a[k] + comp_a[k] + drain_a[k];
    endfunction

    // Model advance: one step of run position per enabled cycle.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] <= 0; m_pos[k] <= 0; m_n[k] <= 0; m_hold[k] <= 0;
            end else if (ge) begin
                if (m_mode[k] == 1) begin
                    m_pos[k] <= m_pos[k] + 1;
                    if (m_pos[k] + 1 == m_n[k] * period(k)) begin
                        m_mode[k] <= 2;
                        m_hold[k] <= m_n[k] - 1;
                    end
                end else if (start) begin
                    m_pos[k]  <= 0;
                    m_hold[k] <= 0;
                    m_n[k]    <= int'(num_tiles);
                    m_mode[k] <= (num_tiles == 8'd0) ? 2 : 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0] lw;
        logic [3:0] em;
        logic       busy;
        logic       td;
        logic       dn;
        logic [7:0] idx;
    } obs_t;

    function automatic obs_t model_out(input int k);
        obs_t o;
        int   off;
        int   r;
        o = '0;
        r = rows_a[k];
        if (m_mode[k] == 1) begin
            off    = m_pos[k] % period(k);
            o.busy = 1'b1;
            o.idx  = 8'(m_pos[k] / period(k));
            if (ge && off < r) o.lw = 4'(1 << off);
            if (ge && off >= r && off < r + comp_a[k]) o.em = 4'((1 << r) - 1);
            o.td = ge && (off == period(k) - 1);
        end else begin
            o.dn  = (m_mode[k] == 2);
            o.idx = 8'(m_hold[k]);
        end
        return o;
    endfunction

    function automatic obs_t dut_out(input int k);
        obs_t o;
        if (k == 0) o = '{lw: {2'b00, lw0}, em: {2'b00, em0}, busy: busy0, td: td0, dn: dn0, idx: idx0};
        else        o = '{lw: lw1, em: em1, busy: busy1, td: td1, dn: dn1, idx: idx1};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        obs_t a, e;
        for (int k = 0; k < 2; k++) begin
            a = dut_out(k);
            e = model_out(k);
            chk($sformatf("u%0d.load_weight", k), 32'(a.lw), 32'(e.lw));
            chk($sformatf("u%0d.enable_mult", k), 32'(a.em), 32'(e.em));
            chk($sformatf("u%0d.busy", k), 32'(a.busy), 32'(e.busy));
            chk($sformatf("u%0d.tile_done", k), 32'(a.td), 32'(e.td));
            chk($sformatf("u%0d.done", k), 32'(a.dn), 32'(e.dn));
            chk($sformatf("u%0d.tile_idx", k), 32'(a.idx), 32'(e.idx));
        end
    endtask

    // Per-run observations used by the literal timing pins.
    logic [3:0] h_lw [2][128];
    logic [3:0] h_em [2][128];
    logic [7:0] h_idx[2][128];
    int n_em[2], n_td[2], n_busy[2], n_lw[2];
    int first_em[2], first_td[2], first_done[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles after the start edge; optional restart attempt and pause window.
    task automatic run(input int ncyc, input int restart_at, input int pause_at, input int pause_len);
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            n_em[k] = 0; n_td[k] = 0; n_busy[k] = 0; n_lw[k] = 0;
            first_em[k] = -1; first_td[k] = -1; first_done[k] = -1;
        end
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            start = 1'b0;
            ge    = !(i >= pause_at && i < pause_at + pause_len);
            if (i == restart_at) begin
                start     = 1'b1;
                num_tiles = 8'd5;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                o = dut_out(k);
                h_lw[k][i]  = o.lw;
                h_em[k][i]  = o.em;
                h_idx[k][i] = o.idx;
                if (o.em != 0) begin n_em[k]++; if (first_em[k] < 0) first_em[k] = i; end
                if (o.td) begin n_td[k]++; if (first_td[k] < 0) first_td[k] = i; end
                if (o.busy) n_busy[k]++;
                if (o.lw != 0) n_lw[k]++;
                if (o.dn && first_done[k] < 0) first_done[k] = i;
            end
        end
    endtask

    task automatic launch(input logic [7:0] n);
        num_tiles = n;
        start     = 1'b1;
        ge        = 1'b1;
    endtask

    task automatic single_tile_scenario(input string tag);
        launch(8'd1);
        run(30, 0, 0, 0);
        chk({tag, ".lw0_c1"}, 32'(h_lw[0][1]), 32'h1);
        chk({tag, ".lw0_c2"}, 32'(h_lw[0][2]), 32'h2);
        chk({tag, ".em0_first"}, 32'(first_em[0]), 32'd3);
        chk({tag, ".em0_count"}, 32'(n_em[0]), 32'd12);
        chk({tag, ".td0_count"}, 32'(n_td[0]), 32'd1);
        chk({tag, ".td0_at"}, 32'(first_td[0]), 32'd18);
        chk({tag, ".done0_at"}, 32'(first_done[0]), 32'd19);
        chk({tag, ".lw1_c3"}, 32'(h_lw[1][3]), 32'h4);
        chk({tag, ".lw1_c4"}, 32'(h_lw[1][4]), 32'h8);
        chk({tag, ".em1_count"}, 32'(n_em[1]), 32'd12);
        chk({tag, ".done1_at"}, 32'(first_done[1]), 32'd21);
    endtask

    initial begin
        rst = 1'b1; ge = 1'b1; start = 1'b0; num_tiles = 8'd0;
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        tick(); tick();
        chk("reset.busy", 32'(busy0), 32'd0);
        chk("reset.done", 32'(dn0), 32'd0);
        rst = 1'b0;
        tick();

        // Single tile from IDLE.
        single_tile_scenario("s1");

        // Three tiles from DONE, with an ignored start (and num_tiles change) mid-run.
        launch(8'd3);
        run(70, 10, 0, 0);
        chk("s2.td0_count", 32'(n_td[0]), 32'd3);
        chk("s2.done0_at", 32'(first_done[0]), 32'd55);
        chk("s2.busy0_cycles", 32'(n_busy[0]), 32'd54);
        chk("s2.idx0_c19", 32'(h_idx[0][19]), 32'd1);
        chk("s2.idx0_c37", 32'(h_idx[0][37]), 32'd2);
        chk("s2.idx0_held", 32'(h_idx[0][60]), 32'd2);
        chk("s2.done1_at", 32'(first_done[1]), 32'd61);

        // Five-cycle pause mid-COMPUTE.
        launch(8'd1);
        run(40, 0, 6, 5);
        chk("s3.em0_count", 32'(n_em[0]), 32'd12);
        chk("s3.em0_paused", 32'(h_em[0][8]), 32'd0);
        chk("s3.td0_at", 32'(first_td[0]), 32'd23);
        chk("s3.done0_at", 32'(first_done[0]), 32'd24);

        // Start together with a pause is dropped.
        start = 1'b1; ge = 1'b0; num_tiles = 8'd2;
        tick();
        start = 1'b0; ge = 1'b1;
        #1;
        chk("s3.drop_busy", 32'(busy0), 32'd0);
        chk("s3.drop_done", 32'(dn0), 32'd1);

        // Asynchronous reset during tile 1 LOAD.
        launch(8'd2);
        run(19, 0, 0, 0);
        chk("s4.pre_lw0", 32'(lw0), 32'h1);
        rst = 1'b1;
        #1;
        chk("s4.rst_lw0", 32'(lw0), 32'h0);
        chk("s4.rst_busy0", 32'(busy0), 32'd0);
        chk("s4.rst_idx0", 32'(idx0), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        single_tile_scenario("s4r");

        // num_tiles=0 from IDLE.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        launch(8'd0);
        run(10, 0, 0, 0);
        chk("s5.done0_at", 32'(first_done[0]), 32'd1);
        chk("s5.busy0_cycles", 32'(n_busy[0]), 32'd0);
        chk("s5.lw0_cycles", 32'(n_lw[0]), 32'd0);

        // Random traffic, checked by the per-cycle model comparison.
        for (int i = 0; i < 3000; i++) begin
            tick();
            ge        = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 19) == 0);
            num_tiles = 8'($urandom_range(0, 3));
            rst       = ($urandom_range(0, 499) == 0);
        end
        tick();
        rst = 1'b0; start = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Control sequencer for a ROWS x COLS systolic array. It runs a programmable number of weight tiles back to back. Each tile goes through three phases: staggered row-by-row weight load, a compute window, and a drain window. The block replaces fixed free-running cycle counting with a start/busy/done handshake, a per-tile completion pulse, and a pause input. It sits between the host/control interface and the PE array's load_weight and enable_mult row controls.

Parameters:
ROWS, 2, PE rows; width of load_weight and enable_mult; must be >= 1
COLS, 2, PE columns; used only in the compute-window length
PE_LATENCY, 4, cycles per PE hop; compute window = (ROWS+COLS-1)*PE_LATENCY cycles
DRAIN_CYCLES, 4, cycles after compute before the tile is considered complete; must be >= 1
TILE_W, 8, width of num_tiles and tile_idx

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
general_enable  input  1  global run/pause; low freezes all state and counters and forces load_weight and enable_mult to 0
start  input  1  begin a run; sampled only in IDLE or DONE with general_enable=1
num_tiles  input  TILE_W  tiles to process; captured on an accepted start
load_weight  output  ROWS  one-hot row weight-load strobe
enable_mult  output  ROWS  per-row multiply enable
busy  output  1  high in LOAD, COMPUTE and DRAIN
tile_done  output  1  one-cycle pulse in the final DRAIN cycle of each tile
tile_idx  output  TILE_W  0-based index of the tile in progress
done  output  1  level; high in DONE only

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all counters=0, captured tile count=0. All outputs are 0.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE. Outputs are Moore, decoded from registered state and counters.
- IDLE/DONE: an accepted start (start=1 and general_enable=1 at an edge) captures num_tiles, clears tile_idx, and moves to LOAD at the next cycle. With num_tiles=0 the block goes to DONE instead. start is ignored while busy=1.
- LOAD: lasts ROWS cycles, phase counter k=0..ROWS-1. load_weight = 1<<k (row 0 first). enable_mult=0.
- COMPUTE: lasts C=(ROWS+COLS-1)*PE_LATENCY cycles. enable_mult = all ones. load_weight=0.
- DRAIN: lasts DRAIN_CYCLES cycles. Both strobe buses are 0. tile_done=1 in the last DRAIN cycle.
- After DRAIN: if tile_idx+1 < captured count, increment tile_idx and go to LOAD. Otherwise go to DONE.
- DONE: done=1, busy=0. tile_idx holds its last value. The block stays in DONE until an accepted start (which clears done in the next cycle) or a reset.
- Latency: accepted start at edge 0 gives the first load_weight strobe in the cycle after edge 0. Per-tile period is ROWS + C + DRAIN_CYCLES cycles. done rises N*(ROWS+C+DRAIN_CYCLES) cycles after the first LOAD cycle.
- Pause: general_enable=0 in any state holds state, phase counter and tile_idx; forces load_weight=0, enable_mult=0 and tile_done=0. busy and done keep their values. A pause during the last cycle of a phase delays the transition by the pause length.
- A start arriving together with general_enable=0 is dropped, not queued.
- Phase counter width is clog2(max(ROWS, C, DRAIN_CYCLES))+1 and never wraps. tile_idx never exceeds the captured count minus 1.
- Changes to num_tiles mid-run have no effect.

Decomposition:
- Package sched_pkg: state enum (IDLE, LOAD, COMPUTE, DRAIN, DONE), function compute_cycles(ROWS, COLS, PE_LATENCY), and a counter-width helper.
- Sub-module phase_counter: loadable down-counter with enable, a last-cycle flag and a zero-based up-count output for the one-hot decode. Instantiated once, reloaded on every phase entry.

Test Plan:
- Defaults (2x2, PE_LATENCY=4, DRAIN=4), num_tiles=1, start pulse -> load_weight 01 then 10, then enable_mult=11 for 12 cycles, then 4 idle cycles with tile_done in the 4th; done=1 18 cycles after the first LOAD cycle.
- num_tiles=3 -> three 18-cycle periods; tile_idx runs 0,1,2; exactly three tile_done pulses; done at cycle 54; busy is continuous with no gap.
- general_enable low for 5 cycles mid-COMPUTE -> enable_mult=0 during the pause; compute window resumes, total 12 active cycles; done delayed by exactly 5.
- Reset asserted mid-LOAD of tile 1 -> outputs 0 immediately (asynchronous). After release, state is IDLE, done=0, and a new start behaves like the first scenario.
- start while busy, and start with num_tiles=0 -> the first is ignored with no timing change; the second gives done=1 one cycle later with no strobes.
- ROWS=4, COLS=3, PE_LATENCY=2 -> load_weight walks 0001,0010,0100,1000; compute window lasts 12 cycles.
